instruction_fetch_unit: RTL and testbench

Front end that feeds the RISC_V_Processor decode stage. Holds the fetch PC and issues in-order word requests to instruction memory over a request/grant port. Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

---
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, in-order imem requests,
// instruction FIFO toward decode, redirect flush.
module instruction_fetch_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] LIM = DEPTH[CW:0];

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     inflight;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic            accept;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            unused_bits;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // buffered plus in-flight never exceeds DEPTH
  assign inflight = {1'b0, count}
                  + {1'b0, outstanding};
  assign imem_req = reset && !redirect_valid
                  && (inflight < LIM);
  assign imem_addr = fetch_pc;
  assign accept = imem_req && imem_gnt;

  assign rsp = imem_rvalid
             && (outstanding != '0);
  assign push = rsp && (drop_cnt == '0)
              && !redirect_valid;

  assign inst_valid = reset && (count != '0)
                    && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst = mem_inst[rptr];
  assign inst_pc = mem_pc[rptr];

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_inst[wptr] <= imem_rdata;
      mem_pc[wptr] <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      resp_pc <= target;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      // everything still in flight is stale
      drop_cnt <= outstanding - CW'(rsp);
      outstanding <= outstanding - CW'(rsp);
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding
                   + CW'(accept) - CW'(rsp);
      if (rsp && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wptr <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      unique case (1'b1)
        (push && !pop): count <= count + CW'(1);
        (pop && !push): count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with
// an in-order memory model and a delivery scoreboard.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] i;
    logic [63:0] pc;
  } exp_t;

  req_t rq[$];
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int epoch = 0;
  int pops = 0;
  int grants = 0;
  int last_qsz = 0;
  logic hold = 1'b1;
  logic want_first = 1'b0;
  logic [63:0] first_pc;
  logic [63:0] first_gaddr;
  logic [63:0] exp_addr = '0;

  function automatic logic [31:0] mk(
    input logic [63:0] a
  );
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cycle();
    req_t r;
    exp_t e;
    logic have_r;
    have_r = 1'b0;
    last_qsz = rq.size();
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if (reset && !hold && rq.size() > 0) begin
      r = rq.pop_front();
      have_r = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = mk(r.addr);
    end
    #1;
    if (!reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
    end
    if (reset && redirect_valid) begin
      chk("redir_req", imem_req, 0);
      chk("redir_valid", inst_valid, 0);
    end
    if (imem_req)
      chk("addr", imem_addr, exp_addr);
    if (inst_valid && inst_ready) begin
      pops++;
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.i);
      end
      if (want_first) begin
        first_pc = inst_pc;
        want_first = 1'b0;
      end
    end
    if (reset && imem_req && imem_gnt) begin
      if (grants == 0)
        first_gaddr = imem_addr;
      grants++;
      rq.push_back('{exp_addr, epoch});
      exp_addr = exp_addr + 64'd4;
    end
    if (have_r && reset && !redirect_valid
        && r.ep == epoch)
      sb.push_back('{mk(r.addr), r.addr});
    if (!reset) begin
      epoch++;
      rq.delete();
      sb.delete();
      exp_addr = '0;
    end else if (redirect_valid) begin
      epoch++;
      sb.delete();
      exp_addr = {redirect_pc[63:2], 2'b00};
    end
    @(posedge clk);
    #1;
    chk("count_le", 64'(dut.count <= 3'd4), 1);
    chk("outst_le",
        64'(dut.outstanding <= 3'd4), 1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++)
      cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    inst_ready = 1'b1;
    hold = 1'b1;
    run(2);
    reset = 1'b1;
    hold = 1'b0;
  endtask

  task automatic arm_first();
    want_first = 1'b1;
    first_pc = 'x;
  endtask

  initial begin
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    do_reset();
    chk("rst_count", dut.count, 0);
    chk("rst_outst", dut.outstanding, 0);
    chk("rst_drop", dut.drop_cnt, 0);

    // streaming
    imem_gnt = 1'b1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    pops = 0;
    arm_first();
    run(10);
    chk("stream_pops", pops, 8);
    chk("stream_first", first_pc, 0);

    // backpressure
    do_reset();
    inst_ready = 1'b0;
    imem_gnt = 1'b1;
    grants = 0;
    run(8);
    chk("bp_grants", grants, 4);
    #1;
    chk("bp_req", imem_req, 0);
    chk("bp_count", dut.count, 4);
    inst_ready = 1'b1;
    grants = 0;
    pops = 0;
    run(8);
    chk("bp_resume", first_gaddr, 64'h10);
    chk("bp_pops_min", 64'(pops >= 4), 1);

    // redirect with 8, C in flight
    do_reset();
    imem_gnt = 1'b1;
    run(3);
    hold = 1'b1;
    run(1);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    run(1);
    chk("r1_drop", dut.drop_cnt, 2);
    redirect_valid = 1'b0;
    hold = 1'b0;
    imem_gnt = 1'b1;
    arm_first();
    run(10);
    chk("r1_first", first_pc, 64'h100);

    // redirect coincident with response
    do_reset();
    imem_gnt = 1'b1;
    run(3);
    hold = 1'b1;
    run(1);
    imem_gnt = 1'b0;
    hold = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    run(1);
    chk("r2_drop", dut.drop_cnt,
        64'(last_qsz - 1));
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("r2_req", imem_req, 1);
    chk("r2_addr", imem_addr, 64'h200);
    arm_first();
    run(10);
    chk("r2_first", first_pc, 64'h200);

    // back-to-back redirects
    do_reset();
    imem_gnt = 1'b1;
    run(3);
    hold = 1'b1;
    run(2);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    run(1);
    redirect_pc = 64'h80;
    run(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    imem_gnt = 1'b1;
    arm_first();
    run(12);
    chk("r3_first", first_pc, 64'h80);

    // reset mid-stream
    do_reset();
    inst_ready = 1'b0;
    imem_gnt = 1'b1;
    run(3);
    hold = 1'b1;
    run(1);
    chk("mid_count", dut.count, 2);
    chk("mid_outst", dut.outstanding, 2);
    reset = 1'b0;
    run(1);
    chk("mid_rcount", dut.count, 0);
    chk("mid_routst", dut.outstanding, 0);
    reset = 1'b1;
    hold = 1'b0;
    inst_ready = 1'b1;
    arm_first();
    run(10);
    chk("mid_first", first_pc, 0);

    // PC wrap
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
    run(1);
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    arm_first();
    run(12);
    chk("wrap_first", first_pc,
        64'hFFFF_FFFF_FFFF_FFF8);
    imem_gnt = 1'b0;
    run(8);
    chk("drain_sb", sb.size(), 0);
    chk("drain_rq", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
